usb_tx_line_encoder: RTL

Serial back end of the USB transmit path. Consumes the bit stream shifted out by the PISO and applies bit stuffing (a 0 after six consecutive 1s) and NRZI encoding. Drives the differential line (dp/dm) and output enable, generates the EOP (SE0, SE0, J). Pulses `done` (wired to the TX FSM's stuffer_done) when the packet has fully left the line.

---
 rtl/usb_tx_line_encoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/usb_tx_line_encoder.sv
// USB transmit line encoder: bit stuffing, NRZI (or raw) line coding and EOP generation.
// Line changes only on bit_tick edges; done pulses as the EOP J symbol goes out.
module usb_tx_line_encoder #(
  parameter int MAX_ONES     = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic clk,
  input  logic nRST,
  input  logic bit_tick,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_last,
  output logic in_ready,
  input  logic nrzi_enable,
  output logic tx_en,
  output logic dp,
  output logic dm,
  output logic stuffing,
  output logic underrun,
  output logic done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] DATA    = 3'd1;
  localparam logic [2:0] STUFF   = 3'd2;
  localparam logic [2:0] EOP_SE0 = 3'd3;
  localparam logic [2:0] EOP_J   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [2:0] MAX_ONES_C = 3'(MAX_ONES);
  localparam logic [1:0] SE0_LAST_C = 2'(EOP_SE0_BITS - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] ones_cnt_q, ones_cnt_d;
  logic [1:0] se0_cnt_q, se0_cnt_d;
  logic       level_q, level_d;
  logic       nrzi_q, nrzi_d;
  logic       last_seen_q, last_seen_d;
  logic       tx_en_q, tx_en_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic       stuffing_q, stuffing_d;
  logic       underrun_q, underrun_d;
  logic       done_q, done_d;

  logic       nrzi_eff;
  logic       data_level;
  logic       data_line;
  logic [2:0] ones_inc;

  assign in_ready = bit_tick & ((state_q == IDLE) | (state_q == DATA));

  // The first bit of a packet uses the live mode input; later bits use the latched mode.
  assign nrzi_eff   = (state_q == IDLE) ? nrzi_enable : nrzi_q;
  assign data_level = in_bit ? level_q : ~level_q;
  assign data_line  = nrzi_eff ? data_level : in_bit;
  assign ones_inc   = ones_cnt_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    ones_cnt_d  = ones_cnt_q;
    se0_cnt_d   = se0_cnt_q;
    level_d     = level_q;
    nrzi_d      = nrzi_q;
    last_seen_d = last_seen_q;
    tx_en_d     = tx_en_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    stuffing_d  = stuffing_q;
    underrun_d  = 1'b0;
    done_d      = 1'b0;

    if (state_q == DONE) begin
      state_d     = IDLE;
      level_d     = 1'b1;
      ones_cnt_d  = 3'd0;
      se0_cnt_d   = 2'd0;
      last_seen_d = 1'b0;
    end else if (bit_tick) begin
      stuffing_d = 1'b0;
      case (state_q)
        IDLE, DATA: begin
          if (in_valid) begin
            if (state_q == IDLE) begin
              nrzi_d  = nrzi_enable;
              tx_en_d = 1'b1;
            end
            if (nrzi_eff) level_d = data_level;
            dp_d        = data_line;
            dm_d        = ~data_line;
            last_seen_d = in_last;
            // A pending stuff bit wins over in_last; last_seen routes STUFF to the EOP.
            if (in_bit && (ones_inc == MAX_ONES_C)) begin
              ones_cnt_d = 3'd0;
              state_d    = STUFF;
            end else begin
              ones_cnt_d = in_bit ? ones_inc : 3'd0;
              state_d    = in_last ? EOP_SE0 : DATA;
            end
          end else if (state_q == DATA) begin
            underrun_d = 1'b1;
          end
        end
        STUFF: begin
          stuffing_d = 1'b1;
          if (nrzi_q) begin
            level_d = ~level_q;
            dp_d    = ~level_q;
            dm_d    = level_q;
          end else begin
            dp_d = 1'b0;
            dm_d = 1'b1;
          end
          state_d = last_seen_q ? EOP_SE0 : DATA;
        end
        EOP_SE0: begin
          dp_d = 1'b0;
          dm_d = 1'b0;
          if (se0_cnt_q == SE0_LAST_C) begin
            se0_cnt_d = 2'd0;
            state_d   = EOP_J;
          end else begin
            se0_cnt_d = se0_cnt_q + 2'd1;
          end
        end
        EOP_J: begin
          dp_d    = 1'b1;
          dm_d    = 1'b0;
          tx_en_d = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ones_cnt_q  <= 3'd0;
      se0_cnt_q   <= 2'd0;
      level_q     <= 1'b1;
      nrzi_q      <= 1'b1;
      last_seen_q <= 1'b0;
      tx_en_q     <= 1'b0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
      stuffing_q  <= 1'b0;
      underrun_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_cnt_q  <= ones_cnt_d;
      se0_cnt_q   <= se0_cnt_d;
      level_q     <= level_d;
      nrzi_q      <= nrzi_d;
      last_seen_q <= last_seen_d;
      tx_en_q     <= tx_en_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      stuffing_q  <= stuffing_d;
      underrun_q  <= underrun_d;
      done_q      <= done_d;
    end
  end

  assign tx_en    = tx_en_q;
  assign dp       = dp_q;
  assign dm       = dm_q;
  assign stuffing = stuffing_q;
  assign underrun = underrun_q;
  assign done     = done_q;

endmodule
